nibble_serial_sub: RTL and testbench
====================================

# nibble_serial_sub

Multi-cycle subtractor computing F = A − B − b_in over WIDTH/4 clock cycles, one 4-bit nibble per cycle, LSB nibble first. Each nibble step uses a 4-bit carry-lookahead stage fed with A, inverted B, and a registered carry. A start/busy/done handshake wraps the block. It is the subtract-direction companion to the team's 4-bit lookahead adder, for datapaths that trade latency for area.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled in IDLE or DONE state only.
- A  input  WIDTH  minuend; sampled on the accepting edge only.
- B  input  WIDTH  subtrahend; sampled on the accepting edge only.
- b_in  input  1  borrow in; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when F and b_out become valid.
- F  output  WIDTH  registered difference; holds its value until the next completion.
- b_out  output  1  registered borrow out; 1 when A < B + b_in (unsigned).
- With `SUB_FLAGS_EN` only: zero, neg, ovf  output  1 each  registered result flags.

## Operation
- States:
  - IDLE: start=1 loads the operand registers. It sets Ar=A, Br=~B, c=~b_in and cnt=0, then goes to RUN.
  - RUN: each edge computes {c4, s} = Ar[3:0] + Br[3:0] + c through the 4-bit lookahead stage.
    - Shifts s into the top of the result shift register, and shifts Ar and Br right by 4.
    - Sets c=c4 and increments cnt.
    - On the edge where cnt = WIDTH/4−1: copies the shift register to F, sets b_out = ~c4, and goes to DONE.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE and goes to RUN. Otherwise the next state is IDLE.
- start during RUN is ignored. The in-flight operation is unaffected.
- A, B and b_in may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH. Borrow semantics: b_out = ~(final carry).
- F and b_out update only on the completion edge. They are never visible mid-operation.
- cnt is wide enough for WIDTH/4−1. cnt resets to 0 on every accept.

## Timing
- Reset, async while rst=1:
  - state = IDLE, busy = 0, done = 0.
  - F = 0, b_out = 0, and the flags = 0.
  - Internal registers = 0.
- Reset asserted mid-operation aborts it. No done pulse is produced.
- Start accepted at edge k: busy=1 after edge k.
- Nibble i is computed at edge k+1+i, for i = 0..N−1 with N = WIDTH/4.
- At edge k+N: busy=0, done=1, and F/b_out are valid.
- done deasserts after edge k+N+1 unless a new result completes at that edge. It cannot, because the minimum period is N+1.
- Back-to-back throughput: one result per N+1 cycles, with start held high.

## Configuration
- `SUB_FLAGS_EN` defined: adds the ports zero, neg and ovf. All three are registered on the completion edge together with F.
  - zero = (F == 0).
  - neg = F[WIDTH−1].
  - ovf = signed overflow, computed as (A[MSB] ≠ B[MSB]) & (F[MSB] ≠ A[MSB]). This requires the operand MSBs to be retained until completion.
- `SUB_FLAGS_EN` not defined: the ports and their logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=16: A=0x1234, B=0x0234, b_in=0 → done after 4 cycles, F=0x1000, b_out=0. With flags: zero=0, neg=0, ovf=0.
- A=0x0000, B=0x0001, b_in=0 → F=0xFFFF, b_out=1. With flags: neg=1, ovf=0.
- A=0x8000, B=0x0001 → F=0x7FFF, b_out=0. With flags: ovf=1, neg=0. Also A=0x0005, B=0x0003, b_in=1 → F=0x0001. Also A=B=0xABCD → F=0, zero=1.
- Start re-pulsed with different operands during RUN → the first result is unchanged, busy stays high, and no extra done pulse appears. Start held high → results complete every 5 cycles, and done is exactly one cycle wide each time.
- rst asserted at nibble 2 → busy=0, done=0 and F=0 immediately. After release, the next start yields a correct result.
- Random A/B/b_in for WIDTH=8, 16 and 32 → F and b_out match the reference model A−B−b_in, and latency equals WIDTH/4 cycles.

Source files
------------

// File: rtl/nibble_serial_sub_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_sub_if
// Handshake and operand/result bundle for nibble_serial_sub.
//   start, A, B, b_in : request and operands (driven by the requester)
//   busy, done        : operation in flight / one-cycle completion pulse
//   F, b_out          : registered difference and borrow out
//   zero, neg, ovf    : result flags, present only when SUB_FLAGS_EN is defined
// Modports: master (requester side), slave (subtractor side).
// -----------------------------------------------------------------------------
interface nibble_serial_sub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] F;
    logic             b_out;
`ifdef SUB_FLAGS_EN
    logic             zero;
    logic             neg;
    logic             ovf;
`endif

`ifdef SUB_FLAGS_EN
    modport master (output start, A, B, b_in,
                    input  busy, done, F, b_out, zero, neg, ovf);
    modport slave  (input  start, A, B, b_in,
                    output busy, done, F, b_out, zero, neg, ovf);
`else
    modport master (output start, A, B, b_in,
                    input  busy, done, F, b_out);
    modport slave  (input  start, A, B, b_in,
                    output busy, done, F, b_out);
`endif
endinterface

// File: rtl/nibble_serial_sub.sv
// -----------------------------------------------------------------------------
// nibble_serial_sub
// Multi-cycle subtractor: F = A - B - b_in, computed one 4-bit nibble per
// clock (LSB nibble first) through a 4-bit carry-lookahead stage fed with A,
// ~B and a registered carry. A result takes WIDTH/4 cycles after acceptance.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : nibble_serial_sub_if.slave (start/A/B/b_in in, busy/done/F/b_out out)
//
// Optional feature: define SUB_FLAGS_EN to add registered zero/neg/ovf flags.
// -----------------------------------------------------------------------------
module nibble_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_sub_if.slave   bus
);
    localparam int N     = WIDTH / 4;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ar;
    logic [WIDTH-1:0] br;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] f_r;
    logic             c;
    logic             b_out_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] cnt;

`ifdef SUB_FLAGS_EN
    // Operand sign bits, kept until completion for the overflow flag.
    logic a_msb;
    logic b_msb;
    logic zero_r;
    logic neg_r;
    logic ovf_r;
`endif

    // 4-bit carry-lookahead add: returns {c4, s[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] cy;
        g     = a & b;
        p     = a ^ b;
        cy[0] = cin;
        cy[1] = g[0] | (p[0] & cin);
        cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
        cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return {cy[4], p ^ cy[3:0]};
    endfunction

    logic [4:0]       step;
    logic [WIDTH-1:0] f_next;
    logic             last;
    logic             accept;

    assign step   = cla4(ar[3:0], br[3:0], c);
    // New nibble enters at the top; after N shifts the LSB nibble sits at bit 0.
    assign f_next = {step[3:0], sr[WIDTH-1:4]};
    assign last   = (cnt == CNT_W'(N - 1));
    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ar      <= '0;
            br      <= '0;
            sr      <= '0;
            f_r     <= '0;
            c       <= 1'b0;
            b_out_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt     <= '0;
`ifdef SUB_FLAGS_EN
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            zero_r  <= 1'b0;
            neg_r   <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                // Subtraction as A + ~B + ~b_in.
                ar     <= bus.A;
                br     <= ~bus.B;
                c      <= ~bus.b_in;
                cnt    <= '0;
                busy_r <= 1'b1;
                state  <= RUN;
`ifdef SUB_FLAGS_EN
                a_msb  <= bus.A[WIDTH-1];
                b_msb  <= bus.B[WIDTH-1];
`endif
            end else begin
                case (state)
                    RUN: begin
                        ar  <= ar >> 4;
                        br  <= br >> 4;
                        sr  <= f_next;
                        c   <= step[4];
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            f_r     <= f_next;
                            b_out_r <= ~step[4];
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state   <= DONE;
`ifdef SUB_FLAGS_EN
                            zero_r  <= (f_next == '0);
                            neg_r   <= f_next[WIDTH-1];
                            ovf_r   <= (a_msb ^ b_msb) & (f_next[WIDTH-1] ^ a_msb);
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.F     = f_r;
    assign bus.b_out = b_out_r;
`ifdef SUB_FLAGS_EN
    assign bus.zero  = zero_r;
    assign bus.neg   = neg_r;
    assign bus.ovf   = ovf_r;
`endif
endmodule

// File: tb/tb_nibble_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_sub
// Directed bench for nibble_serial_sub at WIDTH = 8, 16 and 32. Expected
// values are hand-computed constants or A - B - b_in evaluated in the bench.
// Define SUB_FLAGS_EN to also check the zero/neg/ovf flags (WIDTH = 16 DUT).
// -----------------------------------------------------------------------------
module tb_nibble_serial_sub;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nibble_serial_sub_if #(.WIDTH(8))  i8  ();
    nibble_serial_sub_if #(.WIDTH(16)) i16 ();
    nibble_serial_sub_if #(.WIDTH(32)) i32 ();

    nibble_serial_sub #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));
    nibble_serial_sub #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));
    nibble_serial_sub #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(i32));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic bin);
        case (w)
            8: begin
                i8.start = s; i8.A = a[7:0]; i8.B = b[7:0]; i8.b_in = bin;
            end
            16: begin
                i16.start = s; i16.A = a[15:0]; i16.B = b[15:0]; i16.b_in = bin;
            end
            default: begin
                i32.start = s; i32.A = a; i32.B = b; i32.b_in = bin;
            end
        endcase
    endtask

    task automatic sample(input int w, output logic dn, output logic bz,
                          output logic [31:0] f, output logic bo);
        f = '0;
        case (w)
            8: begin
                dn = i8.done; bz = i8.busy; f[7:0] = i8.F; bo = i8.b_out;
            end
            16: begin
                dn = i16.done; bz = i16.busy; f[15:0] = i16.F; bo = i16.b_out;
            end
            default: begin
                dn = i32.done; bz = i32.busy; f = i32.F; bo = i32.b_out;
            end
        endcase
    endtask

    // One full transaction: accept, bounded wait for done, check result,
    // latency and the single-cycle done pulse.
    task automatic do_op(input string tag, input int w, input logic [31:0] a,
                         input logic [31:0] b, input logic bin,
                         input logic [31:0] ef, input logic ebo,
                         input logic ez, input logic en, input logic eo);
        logic        dn, bz, bo;
        logic [31:0] f;
        int          n;
        drive(w, 1'b1, a, b, bin);
        @(posedge clk); #1;
        drive(w, 1'b0, ~a, ~b, ~bin);
        sample(w, dn, bz, f, bo);
        chk({tag, "_busy"}, bz, 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            sample(w, dn, bz, f, bo);
        end while (!dn && n < w / 4 + 3);
        chk({tag, "_latency"}, n, w / 4);
        chk({tag, "_F"}, f, ef);
        chk({tag, "_b_out"}, bo, ebo);
        chk({tag, "_busy_done"}, bz, 0);
`ifdef SUB_FLAGS_EN
        if (w == 16) begin
            chk({tag, "_zero"}, i16.zero, ez);
            chk({tag, "_neg"}, i16.neg, en);
            chk({tag, "_ovf"}, i16.ovf, eo);
        end
`endif
        @(posedge clk); #1;
        sample(w, dn, bz, f, bo);
        chk({tag, "_done_width"}, dn, 0);
    endtask

    initial begin
        logic [31:0] a, b, m, ef;
        logic [32:0] diff;
        logic        bin;
        int          widths [3] = '{8, 16, 32};

        rst = 1'b1;
        drive(8, 1'b0, 0, 0, 1'b0);
        drive(16, 1'b0, 0, 0, 1'b0);
        drive(32, 1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", i16.busy, 0);
        chk("rst_done", i16.done, 0);
        chk("rst_F", i16.F, 0);
        chk("rst_b_out", i16.b_out, 0);
`ifdef SUB_FLAGS_EN
        chk("rst_zero", i16.zero, 0);
        chk("rst_neg", i16.neg, 0);
        chk("rst_ovf", i16.ovf, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed WIDTH=16 vectors (tag, w, A, B, b_in, F, b_out, zero, neg, ovf).
        do_op("v1234", 16, 32'h1234, 32'h0234, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("v0m1",  16, 32'h0000, 32'h0001, 1'b0, 32'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op("v8000", 16, 32'h8000, 32'h0001, 1'b0, 32'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("vbin",  16, 32'h0005, 32'h0003, 1'b1, 32'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("veq",   16, 32'hABCD, 32'hABCD, 1'b0, 32'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op("vzbin", 16, 32'h0000, 32'h0000, 1'b1, 32'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op("vffff", 16, 32'hFFFF, 32'h0000, 1'b0, 32'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("w8",    8,  32'h10,   32'h01,   1'b1, 32'h0E,   1'b0, 1'b0, 1'b0, 1'b0);
        do_op("w32",   32, 32'h0,    32'h1,    1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);

        // Start re-pulsed during RUN is ignored.
        drive(16, 1'b1, 32'h1234, 32'h0234, 1'b0);
        @(posedge clk); #1;
        drive(16, 1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        drive(16, 1'b1, 32'h5555, 32'h1111, 1'b1);
        chk("rp_busy1", i16.busy, 1);
        @(posedge clk); #1;
        chk("rp_busy2", i16.busy, 1);
        chk("rp_done2", i16.done, 0);
        @(posedge clk); #1;
        chk("rp_busy3", i16.busy, 1);
        chk("rp_done3", i16.done, 0);
        drive(16, 1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        chk("rp_done4", i16.done, 1);
        chk("rp_F", i16.F, 16'h1000);
        @(posedge clk); #1;
        chk("rp_done5", i16.done, 0);
        chk("rp_busy5", i16.busy, 0);
        @(posedge clk); #1;
        chk("rp_done6", i16.done, 0);

        // Start held high: one result every N+1 = 5 cycles.
        drive(16, 1'b1, 32'h8000, 32'h0001, 1'b0);
        @(posedge clk); #1;
        for (int t = 1; t <= 10; t++) begin
            @(posedge clk); #1;
            chk($sformatf("held_done_t%0d", t), i16.done, (t == 4 || t == 9) ? 1 : 0);
            if (t == 4 || t == 9) chk($sformatf("held_F_t%0d", t), i16.F, 16'h7FFF);
            if (t == 5) chk("held_busy_t5", i16.busy, 1);
            if (t == 9) drive(16, 1'b0, 0, 0, 1'b0);
        end

        // Reset asserted at nibble 2 aborts the operation.
        drive(16, 1'b1, 32'h0005, 32'h0003, 1'b1);
        @(posedge clk); #1;
        drive(16, 1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mr_busy", i16.busy, 0);
        chk("mr_done", i16.done, 0);
        chk("mr_F", i16.F, 0);
        chk("mr_b_out", i16.b_out, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mr_done_held", i16.done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mr_no_done", i16.done, 0);
        do_op("mr_after", 16, 32'h0005, 32'h0003, 1'b1, 32'h0001, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random operands against A - B - b_in for each width.
        for (int k = 0; k < 5; k++) begin
            foreach (widths[j]) begin
                m    = (widths[j] == 32) ? 32'hFFFF_FFFF : ((32'h1 << widths[j]) - 32'h1);
                a    = $urandom & m;
                b    = $urandom & m;
                bin  = 1'($urandom_range(0, 1));
                diff = {1'b0, a} - {1'b0, b} - {32'h0, bin};
                ef   = diff[31:0] & m;
                do_op($sformatf("rnd_w%0d_%0d", widths[j], k), widths[j], a, b, bin,
                      ef, diff[widths[j]], (ef == 0), ef[15],
                      (a[15] ^ b[15]) & (ef[15] ^ a[15]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
